// File: rtl/pulse_pattern_receiver_if.sv
// Link bundle between a serial pulse source and pulse_pattern_receiver.
// The source (master) drives the stream and controls; the receiver (slave) returns frame status.
interface pulse_pattern_receiver_if #(
  parameter int WIDTH = 16
);
  logic             in_i;
  logic             sample_en_i;
  logic             clear_i;
  logic [WIDTH-1:0] word_o;
  logic             word_valid_o;
  logic             locked_o;
  logic             mismatch_o;

  modport master (
    output in_i, sample_en_i, clear_i,
    input  word_o, word_valid_o, locked_o, mismatch_o
  );

  modport slave (
    input  in_i, sample_en_i, clear_i,
    output word_o, word_valid_o, locked_o, mismatch_o
  );
endinterface

// File: rtl/pulse_pattern_receiver.sv
// Serial-to-parallel receiver: assembles MSB-first frames and tracks whether
// consecutive frames repeat, reporting lock and per-frame mismatch.
module pulse_pattern_receiver #(
  parameter int WIDTH       = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  pulse_pattern_receiver_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MW = ($clog2(LOCK_FRAMES + 1) > 0) ? $clog2(LOCK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;

  logic [WIDTH-1:0] new_frame;
  logic             frame_done;
  logic [MW-1:0]    match_inc;

  // Match counter never exceeds LOCK_FRAMES so it cannot wrap while locked.
  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (v == MW'(LOCK_FRAMES)) ? v : v + MW'(1);
  endfunction

  assign new_frame  = {shreg_q[WIDTH-2:0], bus.in_i};
  assign frame_done = bus.sample_en_i && (bit_cnt_q == CW'(WIDTH - 1));
  assign match_inc  = sat_inc(match_cnt_q);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    match_cnt_d  = match_cnt_q;
    ref_d        = ref_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    locked_d     = locked_q;
    mismatch_d   = 1'b0;

    if (bus.clear_i) begin
      state_d     = FILL;
      shreg_d     = '0;
      bit_cnt_d   = '0;
      match_cnt_d = '0;
      ref_d       = '0;
      word_d      = '0;
      locked_d    = 1'b0;
    end else if (bus.sample_en_i) begin
      shreg_d   = new_frame;
      bit_cnt_d = frame_done ? '0 : bit_cnt_q + CW'(1);
      if (frame_done) begin
        word_d       = new_frame;
        word_valid_d = 1'b1;
        case (state_q)
          FILL: begin
            ref_d       = new_frame;
            match_cnt_d = '0;
            state_d     = CHECK;
          end
          CHECK: begin
            if (new_frame == ref_q) begin
              match_cnt_d = match_inc;
              if (match_inc == MW'(LOCK_FRAMES)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              mismatch_d  = 1'b1;
              ref_d       = new_frame;
              match_cnt_d = '0;
            end
          end
          LOCKED: begin
            if (new_frame != ref_q) begin
              mismatch_d  = 1'b1;
              locked_d    = 1'b0;
              ref_d       = new_frame;
              match_cnt_d = '0;
              state_d     = CHECK;
            end
          end
          default: state_d = FILL;
        endcase
      end
    end

    // Recover from an illegal encoding regardless of sampling activity.
    if (!(state_q inside {FILL, CHECK, LOCKED})) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FILL;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      match_cnt_q  <= '0;
      ref_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      match_cnt_q  <= match_cnt_d;
      ref_q        <= ref_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
      mismatch_q   <= mismatch_d;
    end
  end

  assign bus.word_o       = word_q;
  assign bus.word_valid_o = word_valid_q;
  assign bus.locked_o     = locked_q;
  assign bus.mismatch_o   = mismatch_q;

endmodule

// File: tb/tb_pulse_pattern_receiver.sv
// Bench for pulse_pattern_receiver: directed scenarios plus randomized traffic,
// checked every cycle against a frame-level reference model.
module tb_pulse_pattern_receiver;

  localparam int W  = 16;
  localparam int LF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_pattern_receiver_if #(.WIDTH(W)) bus ();

  pulse_pattern_receiver #(.WIDTH(W), .LOCK_FRAMES(LF)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bits accumulate into a frame; completed frames form a run
  // of identical frames since the last restart or mismatch.
  logic [W-1:0] m_cur;
  int           m_cnt;
  logic [W-1:0] m_run[$];
  logic [W-1:0] e_word;
  logic         e_wv, e_lock, e_mm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = '0; m_cnt = 0; m_run.delete();
    e_word = '0; e_wv = 1'b0; e_lock = 1'b0; e_mm = 1'b0;
  endtask

  initial begin
    logic s_rst, s_in, s_en, s_clr;
    model_reset();
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_in = bus.in_i; s_en = bus.sample_en_i; s_clr = bus.clear_i;
      #1;
      e_wv = 1'b0;
      e_mm = 1'b0;
      if (!s_rst || s_clr) begin
        model_reset();
      end else if (s_en) begin
        m_cur = {m_cur[W-2:0], s_in};
        m_cnt++;
        if (m_cnt == W) begin
          m_cnt = 0;
          e_word = m_cur;
          e_wv = 1'b1;
          if (m_run.size() > 0 && m_run[m_run.size()-1] != m_cur) begin
            e_mm = 1'b1;
            m_run.delete();
          end
          m_run.push_back(m_cur);
          if (m_run.size() > LF + 1) void'(m_run.pop_front());
          e_lock = (m_run.size() >= LF + 1);
        end
      end
      chk("word", 32'(bus.word_o), 32'(e_word));
      chk("word_valid", 32'(bus.word_valid_o), 32'(e_wv));
      chk("locked", 32'(bus.locked_o), 32'(e_lock));
      chk("mismatch", 32'(bus.mismatch_o), 32'(e_mm));
    end
  end

  task automatic drv(input logic b, input logic e, input logic c);
    @(negedge clk);
    bus.in_i = b; bus.sample_en_i = e; bus.clear_i = c;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [W-1:0] f);
    for (int i = W - 1; i >= 0; i--) drv(f[i], 1'b1, 1'b0);
  endtask

  task automatic pin(input string name, input logic [W-1:0] w, input logic wv,
                     input logic lk, input logic mm);
    chk({name, ".word"}, 32'(bus.word_o), 32'(w));
    chk({name, ".word_valid"}, 32'(bus.word_valid_o), 32'(wv));
    chk({name, ".locked"}, 32'(bus.locked_o), 32'(lk));
    chk({name, ".mismatch"}, 32'(bus.mismatch_o), 32'(mm));
  endtask

  initial begin
    logic [W-1:0] g;
    logic [W-1:0] base;
    logic [W-1:0] f;
    logic [W-1:0] a5c3;
    a5c3 = 16'hA5C3;
    bus.in_i = 1'b0; bus.sample_en_i = 1'b0; bus.clear_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 pin("reset", 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset in the middle of frame 2.
    send_frame(a5c3);
    pin("frame1_pre", a5c3, 1'b1, 1'b0, 1'b0);
    for (int i = W - 1; i >= W - 7; i--) drv(a5c3[i], 1'b1, 1'b0);
    @(negedge clk);
    bus.sample_en_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 pin("async_rst", 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fresh frames after reset: first, lock, steady, error and recovery.
    send_frame(a5c3);
    pin("first", a5c3, 1'b1, 1'b0, 1'b0);
    send_frame(a5c3);
    pin("second", a5c3, 1'b1, 1'b0, 1'b0);
    send_frame(a5c3);
    pin("lock", a5c3, 1'b1, 1'b1, 1'b0);
    send_frame(a5c3);
    pin("hold", a5c3, 1'b1, 1'b1, 1'b0);
    send_frame(16'hA5C2);
    pin("err5", 16'hA5C2, 1'b1, 1'b0, 1'b1);
    send_frame(a5c3);
    pin("err6", a5c3, 1'b1, 1'b0, 1'b1);
    send_frame(a5c3);
    pin("err7", a5c3, 1'b1, 1'b0, 1'b0);
    send_frame(a5c3);
    pin("relock8", a5c3, 1'b1, 1'b1, 1'b0);

    // Five idle cycles inside a frame push word_valid out by exactly five cycles.
    for (int i = W - 1; i >= 8; i--) drv(a5c3[i], 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drv(1'(k % 2), 1'b0, 1'b0);
    for (int i = 7; i >= 1; i--) drv(a5c3[i], 1'b1, 1'b0);
    chk("gap.pre_valid", 32'(bus.word_valid_o), 32'd0);
    drv(a5c3[0], 1'b1, 1'b0);
    pin("gap", a5c3, 1'b1, 1'b1, 1'b0);

    // Clear with a concurrent sample, then end-to-end from a rotating generator.
    drv(1'b1, 1'b1, 1'b1);
    pin("clear", 16'h0, 1'b0, 1'b0, 1'b0);
    g = 16'h8001;
    for (int fr = 1; fr <= 4; fr++) begin
      for (int b = 0; b < W; b++) begin
        drv(g[W-1], 1'b1, 1'b0);
        g = {g[W-2:0], g[W-1]};
      end
      if (fr == 2) pin("gen2", 16'h8001, 1'b1, 1'b0, 1'b0);
      if (fr == 3) pin("gen3", 16'h8001, 1'b1, 1'b1, 1'b0);
    end

    // Randomized traffic: repeating base pattern with gaps, bit errors and clears.
    base = 16'($urandom);
    for (int fr = 0; fr < 120; fr++) begin
      if ($urandom_range(0, 19) == 0) base = 16'($urandom);
      f = base;
      if ($urandom_range(0, 5) == 0) f[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) f = {W{1'($urandom_range(0, 1))}};
      for (int i = W - 1; i >= 0; i--) begin
        while ($urandom_range(0, 5) == 0) drv(1'($urandom), 1'b0, 1'b0);
        if ($urandom_range(0, 299) == 0) drv(1'($urandom), 1'($urandom), 1'b1);
        drv(f[i], 1'b1, 1'b0);
      end
    end

    drv(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
